// File: rtl/bsort_pkg.sv
// rtl/bsort_pkg.sv - shared state type, default width and triangular inner-bound helper
package bsort_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  localparam int BSORT_W = 4;

  // Inner bound for the bubble-sort pass shape, kept to w+1 bits so ub = 2^w-1 never wraps.
  function automatic logic [31:0] tri_jub(input logic [31:0] i, input logic [31:0] lb,
                                          input logic [31:0] ub, input int w);
    logic [31:0] r;
    r = ub - 32'd1 - (i - lb);
    return r & ((32'd1 << (w + 1)) - 32'd1);
  endfunction

endpackage

// File: rtl/bsort_loop_nest_idx.sv
// rtl/bsort_loop_nest_idx.sv - one loop level: loadable index counter with equality bound test
module loop_idx
  import bsort_pkg::*;
#(
  parameter int W = BSORT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] ld_val_i,
  input  logic         inc_i,
  input  logic [W:0]   bound_i,
  output logic [W-1:0] idx_o,
  output logic         at_bound_o
);

  logic [W-1:0] idx_q, idx_d;

  always_comb begin
    idx_d = idx_q;
    if (load_i) begin
      idx_d = ld_val_i;
    end else if (inc_i) begin
      idx_d = idx_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

  assign idx_o      = idx_q;
  assign at_bound_o = ({1'b0, idx_q} == bound_i);

endmodule

// File: rtl/bsort_loop_nest.sv
// rtl/bsort_loop_nest.sv - two-level (i,j) index generator, rectangular or triangular,
// with start/busy/done handshake and consumer-paced advance.
module bsort_loop_nest
  import bsort_pkg::*;
#(
  parameter int W      = BSORT_W,
  parameter bit TRI_EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_i,
  input  logic         abort_i,
  input  logic         tri_mode_i,
  input  logic [W-1:0] lb_i,
  input  logic [W-1:0] ub_i,
  input  logic         adv_i,
  output logic         valid_o,
  output logic [W-1:0] i_o,
  output logic [W-1:0] j_o,
  output logic         last_j_o,
  output logic         last_i_o,
  output logic         busy_o,
  output logic         done_o
);

  state_e       state_q, state_d;
  logic         valid_q, valid_d;
  logic         done_q, done_d;
  logic [W-1:0] lb_q, ub_q;
  logic         tri_q;

  logic         tri_in, empty_in, start_ok;
  logic         load, i_inc, j_inc, j_load;
  logic [W:0]   i_ub, j_ub;
  logic         i_at, j_at;

  assign tri_in   = TRI_EN && tri_mode_i;
  assign empty_in = (lb_i > ub_i) || (tri_in && (lb_i >= ub_i));
  assign start_ok = start_i && !abort_i && (state_q == S_IDLE);

  assign i_ub = tri_q ? ({1'b0, ub_q} - (W+1)'(1)) : {1'b0, ub_q};
  assign j_ub = tri_q ? (W+1)'(tri_jub(32'(i_o), 32'(lb_q), 32'(ub_q), W)) : {1'b0, ub_q};

  loop_idx #(.W(W)) u_outer (
    .clk       (clk),
    .rst       (rst),
    .load_i    (load),
    .ld_val_i  (lb_i),
    .inc_i     (i_inc),
    .bound_i   (i_ub),
    .idx_o     (i_o),
    .at_bound_o(i_at)
  );

  // Inner index reloads from the live lb input on start and from the latched lb on row change.
  loop_idx #(.W(W)) u_inner (
    .clk       (clk),
    .rst       (rst),
    .load_i    (load | j_load),
    .ld_val_i  (load ? lb_i : lb_q),
    .inc_i     (j_inc),
    .bound_i   (j_ub),
    .idx_o     (j_o),
    .at_bound_o(j_at)
  );

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    load    = 1'b0;
    i_inc   = 1'b0;
    j_inc   = 1'b0;
    j_load  = 1'b0;
    if (abort_i) begin
      state_d = S_IDLE;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            if (empty_in) begin
              done_d = 1'b1;
            end else begin
              load    = 1'b1;
              valid_d = 1'b1;
              state_d = S_RUN;
            end
          end
        end
        S_RUN: begin
          if (adv_i && valid_q) begin
            if (!j_at) begin
              j_inc = 1'b1;
            end else if (!i_at) begin
              i_inc  = 1'b1;
              j_load = 1'b1;
            end else begin
              valid_d = 1'b0;
              done_d  = 1'b1;
              state_d = S_IDLE;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      lb_q    <= '0;
      ub_q    <= '0;
      tri_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      if (start_ok) begin
        lb_q  <= lb_i;
        ub_q  <= ub_i;
        tri_q <= tri_in;
      end
    end
  end

  assign valid_o  = valid_q;
  assign done_o   = done_q;
  assign busy_o   = (state_q == S_RUN);
  assign last_j_o = valid_q & j_at;
  assign last_i_o = valid_q & i_at;

endmodule

// File: tb/tb_bsort_loop_nest.sv
// tb/tb_bsort_loop_nest.sv - self-checking bench: queue-of-pairs reference model plus directed/random sweeps
module tb_bsort_loop_nest;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, abort = 1'b0, tri_mode = 1'b0, adv = 1'b0;
  logic [3:0] lb = '0, ub = '0;
  logic       valid, last_j, last_i, busy, done;
  logic [3:0] i, j;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  logic [7:0] mq[$];
  logic [7:0] log_q[$];
  logic [7:0] exp_q[$];
  logic       m_busy = 1'b0, m_done = 1'b0, m_rst = 1'b0, started = 1'b0;

  bsort_loop_nest #(.W(4), .TRI_EN(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start),
    .abort_i   (abort),
    .tri_mode_i(tri_mode),
    .lb_i      (lb),
    .ub_i      (ub),
    .adv_i     (adv),
    .valid_o   (valid),
    .i_o       (i),
    .j_o       (j),
    .last_j_o  (last_j),
    .last_i_o  (last_i),
    .busy_o    (busy),
    .done_o    (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a sweep is the list of (i,j) pairs it must emit; each accept pops one.
  always @(posedge clk) begin
    started = 1'b1;
    m_rst   = rst;
    if (rst) begin
      mq.delete();
      m_busy = 1'b0;
      m_done = 1'b0;
    end else if (abort) begin
      mq.delete();
      m_busy = 1'b0;
      m_done = 1'b0;
    end else if (!m_busy && start) begin
      mq.delete();
      for (int a = int'(lb); a <= (tri_mode ? int'(ub) - 1 : int'(ub)); a++)
        for (int b = int'(lb); b <= (tri_mode ? int'(ub) - 1 - (a - int'(lb)) : int'(ub)); b++)
          mq.push_back({a[3:0], b[3:0]});
      m_busy = (mq.size() > 0);
      m_done = (mq.size() == 0);
    end else if (m_busy && adv) begin
      void'(mq.pop_front());
      m_done = (mq.size() == 0);
      m_busy = !m_done;
    end else begin
      m_done = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("valid", valid, mq.size() > 0);
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      if (mq.size() > 0) begin
        chk("i", i, mq[0][7:4]);
        chk("j", j, mq[0][3:0]);
        chk("last_j", last_j, (mq.size() == 1) || (mq[1][7:4] != mq[0][7:4]));
        chk("last_i", last_i, mq[$][7:4] == mq[0][7:4]);
      end else begin
        chk("last_j_idle", last_j, 1'b0);
        chk("last_i_idle", last_i, 1'b0);
      end
      if (m_rst) begin
        chk("rst_i", i, 0);
        chk("rst_j", j, 0);
      end
      if (done) done_cnt++;
      if (valid && adv && !abort && !rst) log_q.push_back({i, j});
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // mode 0: adv held; 1: 5-cycle stall at (2,2); 2: abort at (1,2); 3: random adv/abort/noise
  task automatic sweep(input logic [3:0] l, input logic [3:0] u, input logic tm, input int mode);
    int  stall = 0;
    bit  fin = 0;
    log_q.delete();
    lb = l; ub = u; tri_mode = tm; start = 1'b1; adv = 1'b1; abort = 1'b0;
    tick();
    start = 1'b0;
    for (int k = 0; k < 600; k++) begin
      if (!busy) begin
        fin = 1;
        break;
      end
      adv = 1'b1;
      if (mode == 1 && i == 2 && j == 2 && stall < 5) begin
        adv = 1'b0;
        stall++;
      end
      if (mode == 2 && i == 1 && j == 2) abort = 1'b1;
      if (mode == 3) begin
        adv      = ($urandom % 4) != 0;
        abort    = ($urandom % 60) == 0;
        start    = ($urandom % 8) == 0;
        lb       = 4'($urandom);
        ub       = 4'($urandom);
        tri_mode = 1'($urandom);
      end
      tick();
      abort = 1'b0;
      start = 1'b0;
    end
    if (!fin) chk("sweep_timeout", 0, 1);
  endtask

  task automatic chk_log(input string name);
    chk({name, "_len"}, log_q.size(), exp_q.size());
    if (log_q.size() == exp_q.size())
      for (int k = 0; k < exp_q.size(); k++) chk(name, log_q[k], exp_q[k]);
  endtask

  initial begin
    int d0;
    repeat (2) tick();
    chk("reset_valid", valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_ij", {i, j}, 8'h00);
    rst = 1'b0;
    tick();

    d0 = done_cnt;
    sweep(4'd1, 4'd3, 1'b0, 0);
    exp_q = '{8'h11, 8'h12, 8'h13, 8'h21, 8'h22, 8'h23, 8'h31, 8'h32, 8'h33};
    chk_log("t1_rect");
    chk("t1_done_now", done, 1);
    tick();
    chk("t1_done_cnt", done_cnt - d0, 1);

    sweep(4'd0, 4'd3, 1'b1, 0);
    exp_q = '{8'h00, 8'h01, 8'h02, 8'h10, 8'h11, 8'h20};
    chk_log("t2_tri");
    tick();

    sweep(4'd1, 4'd3, 1'b0, 1);
    exp_q = '{8'h11, 8'h12, 8'h13, 8'h21, 8'h22, 8'h23, 8'h31, 8'h32, 8'h33};
    chk_log("t3_stall");
    tick();

    d0 = done_cnt;
    sweep(4'd5, 4'd2, 1'b0, 0);
    tick();
    sweep(4'd4, 4'd4, 1'b1, 0);
    tick();
    chk("t4_empty_done", done_cnt - d0, 2);
    chk("t4_empty_log", log_q.size(), 0);

    sweep(4'd14, 4'd15, 1'b0, 0);
    exp_q = '{8'hEE, 8'hEF, 8'hFE, 8'hFF};
    chk_log("t5_top");
    chk("t5_done_now", done, 1);
    sweep(4'd14, 4'd15, 1'b0, 0);
    chk_log("t5_restart");
    tick();

    d0 = done_cnt;
    sweep(4'd1, 4'd3, 1'b0, 2);
    exp_q = '{8'h11};
    chk_log("t6_abort");
    tick();
    chk("t6_no_done", done_cnt - d0, 0);

    lb = 4'd0; ub = 4'd5; tri_mode = 1'b0; start = 1'b1; adv = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    chk("t6_rst_valid", valid, 0);
    chk("t6_rst_ij", {i, j}, 8'h00);
    rst = 1'b0;
    tick();

    for (int n = 0; n < 40; n++) begin
      sweep(4'($urandom), 4'($urandom), 1'($urandom), 3);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
